// File: rtl/ldpc_qc_encoder_if.sv
// rtl/ldpc_qc_encoder_if.sv - stream handshake bundle for the QC-LDPC encoder
// Purpose: groups the info-slice input stream and the coded output stream.
// Signals:
//   in_valid/in_ready/in_data          info slice stream (bit c = u_c[t])
//   out_valid/out_ready/out_data       coded beat stream (info then parity)
//   out_parity                         beat carries parity bits
//   out_last                           final beat of the frame
// Modports: slave = encoder side, master = producer/consumer side.
interface ldpc_qc_encoder_if #(
    parameter int K = 6
) ();
    logic         in_valid;
    logic         in_ready;
    logic [K-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] out_data;
    logic         out_parity;
    logic         out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_parity, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_parity, out_last
    );
endinterface

// File: rtl/ldpc_qc_encoder.sv
// rtl/ldpc_qc_encoder.sv - systematic serial encoder for a 3-row-block QC-LDPC code
// Purpose: forwards L info slices of K bits, then emits L parity beats
//          {0.., p_2[t], p_1[t], p_0[t]} computed from circulant shifts (m*c) mod L.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   en     global enable; low freezes all state and blocks handshakes
//   bus    ldpc_qc_encoder_if.slave stream bundle
module ldpc_qc_encoder #(
    parameter int L          = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int K          = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    ldpc_qc_encoder_if.slave   bus
);
    typedef enum logic {LOAD, PARITY} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   t, t_next;
    logic [2:0][L-1:0]       par, par_next;
    logic                    out_valid_q, out_valid_n;
    logic [K-1:0]            out_data_q, out_data_n;
    logic                    out_parity_q, out_parity_n;
    logic                    out_last_q, out_last_n;
    logic                    out_free;
    logic                    in_fire;

    // Output register can take a new beat when empty or when its beat leaves now.
    assign out_free     = !out_valid_q || bus.out_ready;
    assign bus.in_ready = rst_n && en && (state == LOAD) && out_free;
    assign in_fire      = bus.in_valid && bus.in_ready;

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_parity = out_parity_q;
    assign bus.out_last   = out_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD;
            t            <= '0;
            par          <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_parity_q <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state        <= state_next;
            t            <= t_next;
            par          <= par_next;
            out_valid_q  <= out_valid_n;
            out_data_q   <= out_data_n;
            out_parity_q <= out_parity_n;
            out_last_q   <= out_last_n;
        end
    end

    always_comb begin
        state_next   = state;
        t_next       = t;
        par_next     = par;
        out_valid_n  = out_valid_q;
        out_data_n   = out_data_q;
        out_parity_n = out_parity_q;
        out_last_n   = out_last_q;

        if (en && out_free) begin
            case (state)
                LOAD: begin
                    out_valid_n = in_fire;
                    if (in_fire) begin
                        out_data_n   = bus.in_data;
                        out_parity_n = 1'b0;
                        out_last_n   = 1'b0;
                        // u_c[t] contributes to p_m[(t - m*c) mod L]; all toggles of
                        // the beat fold into one XOR update.
                        for (int m = 0; m < 3; m++) begin
                            for (int c = 0; c < K; c++) begin
                                if (bus.in_data[c]) begin
                                    par_next[m][t - ADDR_WIDTH'(m * c)] =
                                        !par_next[m][t - ADDR_WIDTH'(m * c)];
                                end
                            end
                        end
                        t_next = t + ADDR_WIDTH'(1);
                        if (t == ADDR_WIDTH'(L - 1)) begin
                            state_next = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (out_valid_q && out_last_q) begin
                        // Last parity beat is leaving: restart clean for the next frame.
                        state_next   = LOAD;
                        par_next     = '0;
                        t_next       = '0;
                        out_valid_n  = 1'b0;
                        out_parity_n = 1'b0;
                        out_last_n   = 1'b0;
                    end else begin
                        // t wraps to 0 after beat L-1; out_last stalls further beats.
                        out_valid_n   = 1'b1;
                        out_data_n    = '0;
                        out_data_n[0] = par[0][t];
                        out_data_n[1] = par[1][t];
                        out_data_n[2] = par[2][t];
                        out_parity_n  = 1'b1;
                        out_last_n    = (t == ADDR_WIDTH'(L - 1));
                        t_next        = t + ADDR_WIDTH'(1);
                    end
                end
                default: state_next = LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_ldpc_qc_encoder.sv
// tb/tb_ldpc_qc_encoder.sv - self-checking bench for ldpc_qc_encoder
module tb_ldpc_qc_encoder;
    localparam int L = 32;
    localparam int K = 6;

    logic clk;
    logic rst_n;
    logic en;

    ldpc_qc_encoder_if #(.K(K)) bus ();

    ldpc_qc_encoder #(.L(L), .ADDR_WIDTH(5), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                kind;   // 0 zeros, 1 single bit, 2 all ones
        int                c;
        int                t;
        int                n_exp;
        logic [2:0][4:0]   e_idx;
        logic [2:0][5:0]   e_val;
    } vec_t;

    int          n_cmp;
    int          n_bad;
    int          ni;
    int          no;
    logic [5:0]  info  [L];
    logic [7:0]  exp_b [2*L];
    logic [7:0]  got_b [2*L];
    logic [7:0]  ref_b [2*L];
    vec_t        vecs  [5];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Reference from the code definition: p_m[i] = XOR_c u_c[(i + m*c) mod L].
    task automatic build_exp();
        for (int i = 0; i < L; i++) exp_b[i] = {2'b00, info[i]};
        for (int i = 0; i < L; i++) begin
            logic [2:0] p;
            p = 3'b000;
            for (int m = 0; m < 3; m++)
                for (int c = 0; c < K; c++)
                    p[m] = p[m] ^ info[(i + m * c) % L][c];
            exp_b[L + i] = {(i == L - 1), 1'b1, 3'b000, p};
        end
    endtask

    task automatic run_frame(input bit stall, input int stop_in, input int stop_out);
        int         cyc;
        bit         hold;
        logic [7:0] held;
        ni = 0; no = 0; cyc = 0; hold = 0; held = '0;
        for (int i = 0; i < 2 * L; i++) got_b[i] = 8'hxx;
        while (no < 2 * L && ni != stop_in && no != stop_out && cyc < 3000) begin
            @(negedge clk);
            en           = stall ? ($urandom_range(0, 7) != 0) : 1'b1;
            bus.in_valid = (ni < L) && (!stall || $urandom_range(0, 3) != 0);
            bus.in_data  = bus.in_valid ? info[ni] : 6'($urandom);
            bus.out_ready = !stall || ($urandom_range(0, 1) == 1);
            #1;
            if (hold)
                check("hold", {7'd0, bus.out_valid, bus.out_last, bus.out_parity, bus.out_data},
                      {7'd0, 1'b1, held});
            if (bus.in_valid && bus.in_ready) ni++;
            if (en && bus.out_valid && bus.out_ready) begin
                if (no < 2 * L) got_b[no] = {bus.out_last, bus.out_parity, bus.out_data};
                no++;
            end
            hold = bus.out_valid && !(en && bus.out_ready);
            held = {bus.out_last, bus.out_parity, bus.out_data};
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        en = 1'b1;
        if (cyc >= 3000) check("timeout", 16'(no), 16'(2 * L));
    endtask

    task automatic compare_frame(input string tag);
        for (int i = 0; i < 2 * L; i++)
            check($sformatf("%s beat%0d", tag, i), {8'd0, got_b[i]}, {8'd0, exp_b[i]});
    endtask

    task automatic do_reset(input string tag);
        #3 rst_n = 1'b0;
        #1;
        check({tag, " reset outs"}, {10'd0, bus.in_ready, bus.out_valid, bus.out_parity,
              bus.out_last, 2'b00}, 16'd0);
        check({tag, " reset data"}, {10'd0, bus.out_data}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_info();
        for (int i = 0; i < L; i++) info[i] = 6'($urandom);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; en = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;

        vecs[0] = '{0, 0, 0, 0, {5'd0, 5'd0, 5'd0}, {6'd0, 6'd0, 6'd0}};
        vecs[1] = '{1, 0, 0, 1, {5'd0, 5'd0, 5'd0}, {6'd0, 6'd0, 6'b000111}};
        vecs[2] = '{1, 1, 5, 3, {5'd3, 5'd4, 5'd5}, {6'b000100, 6'b000010, 6'b000001}};
        vecs[3] = '{1, 5, 1, 3, {5'd23, 5'd28, 5'd1}, {6'b000100, 6'b000010, 6'b000001}};
        vecs[4] = '{2, 0, 0, 0, {5'd0, 5'd0, 5'd0}, {6'd0, 6'd0, 6'd0}};

        #12;
        check("reset in_ready", {15'd0, bus.in_ready}, 16'd0);
        check("reset outs", {13'd0, bus.out_valid, bus.out_parity, bus.out_last}, 16'd0);
        check("reset data", {10'd0, bus.out_data}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            int nz;
            for (int i = 0; i < L; i++) info[i] = (vecs[v].kind == 2) ? 6'h3f : 6'h00;
            if (vecs[v].kind == 1) info[vecs[v].t][vecs[v].c] = 1'b1;
            build_exp();
            run_frame(1'b0, -1, -1);
            compare_frame($sformatf("vec%0d", v));
            nz = 0;
            for (int i = 0; i < L; i++) if (got_b[L + i][5:0] != 6'd0) nz++;
            check($sformatf("vec%0d nonzero", v), 16'(nz), 16'(vecs[v].n_exp));
            for (int j = 0; j < vecs[v].n_exp; j++)
                check($sformatf("vec%0d hand p%0d", v, j),
                      {10'd0, got_b[L + int'(vecs[v].e_idx[j])][5:0]}, {10'd0, vecs[v].e_val[j]});
        end

        // Stalled run must reproduce the unstalled output sequence.
        random_info();
        build_exp();
        run_frame(1'b0, -1, -1);
        compare_frame("rnd");
        for (int i = 0; i < 2 * L; i++) ref_b[i] = got_b[i];
        run_frame(1'b1, -1, -1);
        for (int i = 0; i < 2 * L; i++)
            check($sformatf("stall beat%0d", i), {8'd0, got_b[i]}, {8'd0, ref_b[i]});

        // Reset mid-info and mid-parity, then a clean frame.
        random_info();
        build_exp();
        run_frame(1'b0, 17, -1);
        do_reset("info17");
        run_frame(1'b0, -1, L + 9);
        do_reset("par9");
        run_frame(1'b0, -1, -1);
        compare_frame("postrst");

        // Back-to-back: busy frame followed by an all-zero frame.
        random_info();
        build_exp();
        run_frame(1'b0, -1, -1);
        compare_frame("b2b1");
        for (int i = 0; i < L; i++) info[i] = 6'h00;
        build_exp();
        run_frame(1'b0, -1, -1);
        compare_frame("b2b0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
